hazard_stall_unit: RTL and testbench

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

---
 rtl/hazard_pkg.sv | 14 +
 rtl/sat_counter.sv | 23 ++
 rtl/hazard_stall_unit.sv | 112 +++++++++++
 tb/tb_hazard_stall_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and default parameters for the load-use hazard / stall controller.
// Pure declarations; no timing or flow control of its own.
package hazard_pkg;

    localparam int REG_AW_DEF   = 5;
    localparam int LOAD_LAT_DEF = 1;
    localparam int CNT_W_DEF    = 16;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LSTALL = 1'b1
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones; clr wins over inc.
// One-cycle update latency; no backpressure, inc is sampled every cycle.
module sat_counter #(
    parameter int CNT_W = hazard_pkg::CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use stall / branch flush controller with mem_busy freeze and saturating event counters.
// Zero-latency combinational controls; mem_busy freezes the front end and holds all state.
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int LOAD_LAT = LOAD_LAT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_ex_mem_read,
    input  logic              id_ex_mem_write,
    input  logic [REG_AW-1:0] id_ex_rt,
    input  logic [REG_AW-1:0] if_id_rs,
    input  logic [REG_AW-1:0] if_id_rt,
    input  logic              if_id_uses_rt,
    input  logic              branch_taken,
    input  logic              mem_busy,
    input  logic              cnt_clr,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              stall_ctrl,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam logic [2:0] REM_INIT = 3'(LOAD_LAT - 1);

    state_t     state, state_n;
    logic [2:0] rem, rem_n;
    logic       pend_flush, pend_flush_n;
    logic       hazard;
    logic       flush_now;

    assign hazard = id_ex_mem_read && !id_ex_mem_write && (id_ex_rt != '0) &&
                    ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));

    assign flush_now = branch_taken || pend_flush;

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        stall_ctrl   = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        state_n      = state;
        rem_n        = rem;
        pend_flush_n = 1'b0;

        // Reset forces normal-flow controls even if hazard inputs are live.
        if (!reset) begin
            if (mem_busy) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                pend_flush_n = pend_flush || branch_taken;
            end else if (flush_now) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                state_n     = IDLE;
                rem_n       = 3'd0;
            end else if (state == LSTALL) begin
                pc_en      = 1'b0;
                if_id_en   = 1'b0;
                stall_ctrl = 1'b1;
                rem_n      = rem - 3'd1;
                if (rem == 3'd1) begin
                    state_n = IDLE;
                end
            end else if (hazard) begin
                pc_en      = 1'b0;
                if_id_en   = 1'b0;
                stall_ctrl = 1'b1;
                if (LOAD_LAT > 1) begin
                    state_n = LSTALL;
                    rem_n   = REM_INIT;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rem        <= 3'd0;
            pend_flush <= 1'b0;
        end else begin
            state      <= state_n;
            rem        <= rem_n;
            pend_flush <= pend_flush_n;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_ctrl),
        .clr   (cnt_clr),
        .count (stall_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (if_id_flush),
        .clr   (cnt_clr),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed-vector scoreboard bench: instance A (LOAD_LAT=3, 16-bit counters), instance B (LOAD_LAT=1, 2-bit counters).
module tb_hazard_stall_unit;

    typedef struct packed {
        logic       rst;
        logic       mr;
        logic       mw;
        logic [4:0] ex_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       br;
        logic       busy;
        logic       clr;
    } stim_t;

    typedef struct packed {
        logic        pc;
        logic        ifid;
        logic        st;
        logic        fl;
        logic [15:0] sc;
        logic [15:0] fc;
        logic [15:0] step;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    stim_t sa, sb;
    logic        a_pc, a_ifid, a_st, a_iff, a_exf;
    logic [15:0] a_sc, a_fc;
    logic        b_pc, b_ifid, b_st, b_iff, b_exf;
    logic [1:0]  b_sc, b_fc;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   passed = 0;
    int   step_no = 0;

    hazard_stall_unit #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) dut_a (
        .clk             (clk),
        .reset           (sa.rst),
        .id_ex_mem_read  (sa.mr),
        .id_ex_mem_write (sa.mw),
        .id_ex_rt        (sa.ex_rt),
        .if_id_rs        (sa.rs),
        .if_id_rt        (sa.rt),
        .if_id_uses_rt   (sa.uses_rt),
        .branch_taken    (sa.br),
        .mem_busy        (sa.busy),
        .cnt_clr         (sa.clr),
        .pc_en           (a_pc),
        .if_id_en        (a_ifid),
        .stall_ctrl      (a_st),
        .if_id_flush     (a_iff),
        .id_ex_flush     (a_exf),
        .stall_count     (a_sc),
        .flush_count     (a_fc)
    );

    hazard_stall_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(2)) dut_b (
        .clk             (clk),
        .reset           (sb.rst),
        .id_ex_mem_read  (sb.mr),
        .id_ex_mem_write (sb.mw),
        .id_ex_rt        (sb.ex_rt),
        .if_id_rs        (sb.rs),
        .if_id_rt        (sb.rt),
        .if_id_uses_rt   (sb.uses_rt),
        .branch_taken    (sb.br),
        .mem_busy        (sb.busy),
        .cnt_clr         (sb.clr),
        .pc_en           (b_pc),
        .if_id_en        (b_ifid),
        .stall_ctrl      (b_st),
        .if_id_flush     (b_iff),
        .id_ex_flush     (b_exf),
        .stall_count     (b_sc),
        .flush_count     (b_fc)
    );

    function automatic stim_t s(input logic mr, input logic mw, input logic [4:0] ex_rt,
                                input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                                input logic br, input logic busy, input logic clr, input logic rst);
        stim_t r;
        r.rst = rst; r.mr = mr; r.mw = mw; r.ex_rt = ex_rt; r.rs = rs; r.rt = rt;
        r.uses_rt = uses; r.br = br; r.busy = busy; r.clr = clr;
        return r;
    endfunction

    function automatic exp_t ex(input logic pc, input logic ifid, input logic st, input logic fl,
                                input int sc, input int fc);
        exp_t r;
        r.pc = pc; r.ifid = ifid; r.st = st; r.fl = fl;
        r.sc = 16'(sc); r.fc = 16'(fc); r.step = 16'(step_no);
        return r;
    endfunction

    task automatic cmp(input string nm, input int step, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s step %0d: got %0d expected %0d", nm, step, act, req);
    endtask

    // Monitor: one scoreboard entry per instance per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            cmp("A.pc_en",       int'(e.step), int'(a_pc),   int'(e.pc));
            cmp("A.if_id_en",    int'(e.step), int'(a_ifid), int'(e.ifid));
            cmp("A.stall_ctrl",  int'(e.step), int'(a_st),   int'(e.st));
            cmp("A.if_id_flush", int'(e.step), int'(a_iff),  int'(e.fl));
            cmp("A.id_ex_flush", int'(e.step), int'(a_exf),  int'(e.fl));
            cmp("A.stall_count", int'(e.step), int'(a_sc),   int'(e.sc));
            cmp("A.flush_count", int'(e.step), int'(a_fc),   int'(e.fc));
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            cmp("B.pc_en",       int'(e.step), int'(b_pc),   int'(e.pc));
            cmp("B.if_id_en",    int'(e.step), int'(b_ifid), int'(e.ifid));
            cmp("B.stall_ctrl",  int'(e.step), int'(b_st),   int'(e.st));
            cmp("B.if_id_flush", int'(e.step), int'(b_iff),  int'(e.fl));
            cmp("B.id_ex_flush", int'(e.step), int'(b_exf),  int'(e.fl));
            cmp("B.stall_count", int'(e.step), int'(b_sc),   int'(e.sc));
            cmp("B.flush_count", int'(e.step), int'(b_fc),   int'(e.fc));
        end
    end

    task automatic step_a(input stim_t st, input exp_t e);
        sa = st;
        sb = s(0,0,0,0,0,0,0,0,0,0);
        qa.push_back(e);
        @(posedge clk); #1;
        step_no++;
    endtask

    task automatic step_b(input stim_t st, input exp_t e);
        sb = st;
        sa = s(0,0,0,0,0,0,0,0,0,0);
        qb.push_back(e);
        @(posedge clk); #1;
        step_no++;
    endtask

    initial begin
        sa = s(1,0,5,5,0,0,0,0,0,1);
        sb = s(1,0,5,5,0,0,0,0,0,1);
        @(posedge clk); #1;

        // Reset with a live hazard on the inputs: controls must still be normal.
        qa.push_back(ex(1,1,0,0,0,0));
        qb.push_back(ex(1,1,0,0,0,0));
        @(posedge clk); #1;
        step_no++;

        // Instance A, LOAD_LAT=3
        step_a(s(0,0,0,0,0,0,0,0,0,0), ex(1,1,0,0,0,0));
        step_a(s(1,0,7,3,7,1,0,0,0,0), ex(0,0,1,0,0,0));  // rt-side hazard
        step_a(s(1,0,7,3,7,1,0,0,0,0), ex(0,0,1,0,1,0));
        step_a(s(1,0,7,3,7,1,0,0,0,0), ex(0,0,1,0,2,0));
        step_a(s(0,0,0,3,7,1,0,0,0,0), ex(1,1,0,0,3,0));
        step_a(s(1,0,0,0,0,0,0,0,0,0), ex(1,1,0,0,3,0));  // r0 never hazards
        step_a(s(1,1,5,5,0,0,0,0,0,0), ex(1,1,0,0,3,0));  // store suppresses
        step_a(s(1,0,5,9,5,0,0,0,0,0), ex(1,1,0,0,3,0));  // rt match but unused
        step_a(s(1,0,4,4,0,0,0,0,0,0), ex(0,0,1,0,3,0));
        step_a(s(1,0,4,4,0,0,1,0,0,0), ex(1,1,0,1,4,0));  // branch aborts stall
        step_a(s(0,0,0,0,0,0,0,0,0,0), ex(1,1,0,0,4,1));
        step_a(s(0,0,0,0,0,0,1,1,0,0), ex(0,0,0,0,4,1));  // branch under busy
        step_a(s(0,0,0,0,0,0,0,1,0,0), ex(0,0,0,0,4,1));
        step_a(s(0,0,0,0,0,0,0,0,0,0), ex(1,1,0,1,4,1));  // deferred flush
        step_a(s(0,0,0,0,0,0,0,0,0,0), ex(1,1,0,0,4,2));
        step_a(s(1,0,6,6,0,0,0,0,0,0), ex(0,0,1,0,4,2));
        step_a(s(1,0,6,6,0,0,0,1,0,0), ex(0,0,0,0,5,2));  // busy mid-stall
        step_a(s(1,0,6,6,0,0,0,1,0,0), ex(0,0,0,0,5,2));
        step_a(s(1,0,6,6,0,0,0,0,0,0), ex(0,0,1,0,5,2));
        step_a(s(1,0,6,6,0,0,0,0,0,0), ex(0,0,1,0,6,2));
        step_a(s(0,0,0,6,0,0,0,0,0,0), ex(1,1,0,0,7,2));
        step_a(s(1,0,2,2,0,0,0,0,0,0), ex(0,0,1,0,7,2));
        step_a(s(0,0,0,0,0,0,0,0,0,1), ex(1,1,0,0,0,0));  // reset mid-stall
        step_a(s(0,0,0,0,0,0,0,0,0,0), ex(1,1,0,0,0,0));
        step_a(s(1,0,2,2,0,0,0,0,1,0), ex(0,0,1,0,0,0));  // clr beats increment
        step_a(s(0,0,0,0,0,0,0,0,0,0), ex(0,0,1,0,0,0));
        step_a(s(0,0,0,0,0,0,0,0,0,0), ex(0,0,1,0,1,0));
        step_a(s(0,0,0,0,0,0,0,0,0,0), ex(1,1,0,0,2,0));

        // Instance B, LOAD_LAT=1, counters saturate at 3
        step_b(s(1,0,5,5,0,0,0,0,0,0), ex(0,0,1,0,0,0));
        step_b(s(0,0,0,5,0,0,0,0,0,0), ex(1,1,0,0,1,0));
        step_b(s(1,0,5,5,0,0,0,0,0,0), ex(0,0,1,0,1,0));
        step_b(s(1,0,5,5,0,0,0,0,0,0), ex(0,0,1,0,2,0));
        step_b(s(1,0,5,5,0,0,0,0,0,0), ex(0,0,1,0,3,0));
        step_b(s(0,0,0,0,0,0,0,0,0,0), ex(1,1,0,0,3,0));  // saturated
        step_b(s(0,0,0,0,0,0,0,0,1,0), ex(1,1,0,0,3,0));
        step_b(s(0,0,0,0,0,0,0,0,0,0), ex(1,1,0,0,0,0));
        step_b(s(0,0,0,0,0,0,1,0,0,0), ex(1,1,0,1,0,0));
        step_b(s(0,0,0,0,0,0,0,0,0,0), ex(1,1,0,0,0,1));

        repeat (2) @(posedge clk);
        checks++;
        if ((qa.size() == 0) && (qb.size() == 0)) passed++;
        else $display("FAIL scoreboard_drain: got %0d/%0d entries left, expected 0/0", qa.size(), qb.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
